sprite_compositor: RTL and testbench
====================================

# sprite_compositor

Parametrised N-channel sprite compositor for the VGA pixel path. For each of N_SPR sprites it computes the window hit and the ROM address from the current raster position. It aligns the registered ROM data through a pipeline and composites the channels by fixed priority over a background colour. It also detects pixel-level overlaps between opaque sprites and reports them as per-channel collision flags, a hold-stretched event vector and a per-frame summary. The game FSM consumes these outputs in place of the fixed dragon/robot/missile compositor.

## Interface
Parameters:
- N_SPR, 4, number of sprite channels; channel 0 has the highest priority
- ADDR_W, 12, ROM address width per channel
- HOLD_BITS, 20, event hold counter width; hold lasts 2^(HOLD_BITS-1) cycles
- BG_COLOR, 12'hfff, output colour where no sprite is opaque
- KEY_COLOR, 12'hfff, transparent colour key in ROM data

Ports:
- clk_25Hz  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- h_cnt, v_cnt  in  10 each  raster position
- spr_en  in  N_SPR  channel enable
- spr_x, spr_y  in  N_SPR*10  top-left corner per channel, packed with channel i at [10i+9:10i]
- spr_w, spr_h  in  N_SPR*10  sprite size per channel
- rom_addr  out  N_SPR*ADDR_W  combinational address per channel
- rom_data  in  N_SPR*12  ROM output, valid one cycle after rom_addr
- pixel  out  12  composited colour (registered)
- hit  out  N_SPR  per-pixel collision flags (registered)
- event  out  N_SPR  hold-stretched collision vector
- frame_hits  out  N_SPR  OR of hit over the previous frame

## Operation
- Window test, per channel, evaluated in 11-bit arithmetic so there is no wrap:
  - in_i = spr_en[i] & h_cnt>=x & (h_cnt-x)<w & v_cnt>=y & (v_cnt-y)<h
  - w=0 or h=0 means the channel is never in range.
- Address: rom_addr_i = (dy*w + dx) truncated to ADDR_W bits when in_i, else 0.
- Stage 1 registers in_i and a frame-start flag (h_cnt==0 & v_cnt==0).
- Opacity: op_i = in_i_d1 & (rom_data_i != KEY_COLOR).
- Compositing:
  - pixel <= rom_data of the lowest-index channel with op_i set
  - pixel <= BG_COLOR when no channel is opaque
- Collision: hit_i <= op_i & (some other op_j is set). This requires two or more opaque channels at the same pixel; a single opaque channel never sets hit.
- Event, single shared counter cnt[HOLD_BITS-1:0]:
  - If hit != 0 and hit != event: event <= hit, cnt <= 0.
  - Else if cnt MSB is 0: cnt increments.
  - Else: event <= 0.
  - A repeated identical hit does not restart the hold.
- Frame summary:
  - Accumulator acc |= hit each cycle.
  - When the stage-1 frame-start flag is set: frame_hits <= acc (including that cycle's hit), and acc <= 0.
- Reset values: pixel=BG_COLOR; hit, event, frame_hits, acc, cnt and pipeline flags all 0.
- Reset asserted mid-hold clears event immediately on the next edge.

## Timing
- rom_addr is combinational from h_cnt/v_cnt/spr_*; the ROM adds one cycle.
- pixel and hit appear 2 cycles after the h_cnt/v_cnt they correspond to.
- event updates one cycle after hit and holds 2^(HOLD_BITS-1) cycles after the last change.
- frame_hits updates 2 cycles after raster (0,0) and stays stable for the whole frame.
- spr_* may change at any time; the pipeline uses the values sampled at stage 0.

## Configuration
- SPRITE_COLLISION_EN defined: hit, event and frame_hits logic, plus the counter, are built.
- SPRITE_COLLISION_EN undefined: hit, event and frame_hits are tied to 0 and no counter or accumulator exists. Compositing and pixel latency are unchanged.

## Structure
- Package sprite_pkg holds:
  - COLOR_W=12 and COORD_W=10
  - the default BG/KEY colours
  - a function that extracts channel i from a packed vector
- Sub-module sprite_window contains one channel's range test and address multiply. It is instantiated N_SPR times in a generate loop.
- Top level holds the pipeline registers, priority mux, collision logic and event/frame registers.

## Test plan
- Reset with rst=1 for 3 cycles -> pixel=12'hfff, hit=event=frame_hits=0.
- Channel 0 at (100,50) size 40x30, ROM returns 12'h0f0, raster at (110,60) -> rom_addr=410; pixel=12'h0f0 2 cycles later; hit=0.
- Channels 0 and 2 overlap opaque at (120,60) -> pixel=ch0 data, hit=4'b0101; event=4'b0101 next cycle; event clears after 2^19 cycles with no new hit.
- Overlap where ch2 data=12'hfff (key) -> hit=0, pixel=ch0 data; with both keyed -> pixel=12'hfff.
- Collision occurs once in frame k -> frame_hits shows the mask 2 cycles after (0,0) of frame k+1 and returns to 0 at frame k+2.
- spr_w=0 or spr_en=0 on a channel covering the raster -> rom_addr=0, the channel is never composited, and no hit occurs.

Source files
------------

// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared widths, default colours and a channel-extraction helper for the
// sprite compositor and its per-channel window sub-module.
// -----------------------------------------------------------------------------
package sprite_pkg;

    localparam int COLOR_W = 12;
    localparam int COORD_W = 10;

    // Upper bound on channel count accepted by chan_coord().
    localparam int MAX_SPR = 16;
    localparam int PACK_W  = MAX_SPR * COORD_W;

    localparam logic [COLOR_W-1:0] DEF_BG_COLOR  = 12'hfff;
    localparam logic [COLOR_W-1:0] DEF_KEY_COLOR = 12'hfff;

    // Returns channel i of a packed coordinate vector (channel i at
    // [COORD_W*i +: COORD_W]). Callers zero-extend their vector to PACK_W.
    function automatic logic [COORD_W-1:0] chan_coord(input logic [PACK_W-1:0] vec,
                                                      input int               i);
        return vec[i*COORD_W +: COORD_W];
    endfunction

endpackage

// File: rtl/sprite_window.sv
// -----------------------------------------------------------------------------
// sprite_window
// One channel's window test and ROM address generation, purely combinational.
//
// Ports:
//   spr_en        channel enable
//   h_cnt, v_cnt  raster position
//   x, y          sprite top-left corner
//   w, h          sprite size (0 in either dimension disables the window)
//   in_win        raster lies inside the enabled window
//   rom_addr      dy*w + dx truncated to ADDR_W when in_win, else 0
// -----------------------------------------------------------------------------
module sprite_window
    import sprite_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic               spr_en,
    input  logic [COORD_W-1:0] h_cnt,
    input  logic [COORD_W-1:0] v_cnt,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] w,
    input  logic [COORD_W-1:0] h,
    output logic               in_win,
    output logic [ADDR_W-1:0]  rom_addr
);

    // One extra bit so the offsets never wrap when raster < corner.
    logic [COORD_W:0]     dx;
    logic [COORD_W:0]     dy;
    logic [2*COORD_W-1:0] prod;
    logic [2*COORD_W:0]   addr_full;

    always_comb begin
        dx = {1'b0, h_cnt} - {1'b0, x};
        dy = {1'b0, v_cnt} - {1'b0, y};

        // dx < w with w == 0 is never true, so zero-size sprites drop out here.
        in_win = spr_en && (h_cnt >= x) && (dx < {1'b0, w})
                        && (v_cnt >= y) && (dy < {1'b0, h});

        // Inside the window dy < h <= 1023, so the low COORD_W bits are exact.
        prod      = dy[COORD_W-1:0] * w;
        addr_full = {1'b0, prod} + {{(COORD_W+1){1'b0}}, dx[COORD_W-1:0]};
        rom_addr  = in_win ? addr_full[ADDR_W-1:0] : '0;
    end

endmodule

// File: rtl/sprite_compositor.sv
// -----------------------------------------------------------------------------
// sprite_compositor
// N_SPR-channel sprite compositor for the VGA pixel path. Generates per-channel
// ROM addresses from the raster position, aligns the one-cycle ROM data with a
// stage-1 register, composites by fixed priority (channel 0 highest) over
// BG_COLOR and, optionally, reports overlaps between opaque channels.
//
// Build option: define SPRITE_COLLISION_EN to build the hit / event_hold /
// frame_hits logic; otherwise those outputs are tied to 0.
//
// Ports:
//   clk_25Hz      pixel clock
//   rst           synchronous active-high reset
//   h_cnt, v_cnt  raster position
//   spr_en        per-channel enable
//   spr_x, spr_y  per-channel top-left corner, channel i at [10i+9:10i]
//   spr_w, spr_h  per-channel size, same packing
//   rom_addr      combinational ROM address per channel
//   rom_data      ROM output per channel, valid one cycle after rom_addr
//   pixel         composited colour, two cycles after the raster position
//   hit           per-channel collision flags, aligned with pixel
//   event_hold    collision vector held 2^(HOLD_BITS-1) cycles after a change
//   frame_hits    OR of hit over the previous frame
// -----------------------------------------------------------------------------
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int                 N_SPR     = 4,
    parameter int                 ADDR_W    = 12,
    parameter int                 HOLD_BITS = 20,
    parameter logic [COLOR_W-1:0] BG_COLOR  = DEF_BG_COLOR,
    parameter logic [COLOR_W-1:0] KEY_COLOR = DEF_KEY_COLOR
) (
    input  logic                      clk_25Hz,
    input  logic                      rst,
    input  logic [COORD_W-1:0]        h_cnt,
    input  logic [COORD_W-1:0]        v_cnt,
    input  logic [N_SPR-1:0]          spr_en,
    input  logic [N_SPR*COORD_W-1:0]  spr_x,
    input  logic [N_SPR*COORD_W-1:0]  spr_y,
    input  logic [N_SPR*COORD_W-1:0]  spr_w,
    input  logic [N_SPR*COORD_W-1:0]  spr_h,
    output logic [N_SPR*ADDR_W-1:0]   rom_addr,
    input  logic [N_SPR*COLOR_W-1:0]  rom_data,
    output logic [COLOR_W-1:0]        pixel,
    output logic [N_SPR-1:0]          hit,
    output logic [N_SPR-1:0]          event_hold,
    output logic [N_SPR-1:0]          frame_hits
);

    if (N_SPR > MAX_SPR || N_SPR < 1 || HOLD_BITS < 2) begin : g_param_check
        $error("sprite_compositor: unsupported N_SPR or HOLD_BITS");
    end

    // ---------------- Stage 0: window test and address ----------------------
    logic [PACK_W-1:0] x_ext, y_ext, w_ext, h_ext;
    logic [N_SPR-1:0]  in_win;

    assign x_ext = PACK_W'(spr_x);
    assign y_ext = PACK_W'(spr_y);
    assign w_ext = PACK_W'(spr_w);
    assign h_ext = PACK_W'(spr_h);

    for (genvar i = 0; i < N_SPR; i++) begin : g_win
        sprite_window #(.ADDR_W(ADDR_W)) u_win (
            .spr_en   (spr_en[i]),
            .h_cnt    (h_cnt),
            .v_cnt    (v_cnt),
            .x        (chan_coord(x_ext, i)),
            .y        (chan_coord(y_ext, i)),
            .w        (chan_coord(w_ext, i)),
            .h        (chan_coord(h_ext, i)),
            .in_win   (in_win[i]),
            .rom_addr (rom_addr[i*ADDR_W +: ADDR_W])
        );
    end

    // ---------------- Stage 1: align with registered ROM data ---------------
    logic [N_SPR-1:0] in_d1;
    logic             frame_d1;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_25Hz) begin
        if (rst) begin
            in_d1    <= '0;
            frame_d1 <= 1'b0;
        end else begin
            in_d1    <= in_win;
            frame_d1 <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    // ---------------- Opacity and priority mux ------------------------------
    logic [N_SPR-1:0]   op;
    logic [COLOR_W-1:0] pixel_nxt;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a missed path infers a latch.
        op        = '0;
        pixel_nxt = BG_COLOR;
        for (int i = 0; i < N_SPR; i++) begin
            op[i] = in_d1[i] && (rom_data[i*COLOR_W +: COLOR_W] != KEY_COLOR);
        end
        // Walk from lowest priority upward so channel 0 wins last.
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (op[i]) pixel_nxt = rom_data[i*COLOR_W +: COLOR_W];
        end
    end

    always_ff @(posedge clk_25Hz) begin
        if (rst) pixel <= BG_COLOR;
        else     pixel <= pixel_nxt;
    end

    // ---------------- Collision, event hold, frame summary ------------------
`ifdef SPRITE_COLLISION_EN
    logic [N_SPR-1:0]     hit_nxt;
    logic [N_SPR-1:0]     acc;
    logic [HOLD_BITS-1:0] cnt;

    always_comb begin
        hit_nxt = '0;
        for (int i = 0; i < N_SPR; i++) begin
            // A channel collides only if some *other* channel is also opaque.
            hit_nxt[i] = op[i] && ((op & ~(N_SPR'(1) << i)) != '0);
        end
    end

    always_ff @(posedge clk_25Hz) begin
        if (rst) begin
            hit        <= '0;
            event_hold <= '0;
            cnt        <= '0;
            acc        <= '0;
            frame_hits <= '0;
        end else begin
            hit <= hit_nxt;

            // Only a changed, non-empty hit vector restarts the hold, so a
            // collision persisting across pixels does not stretch it forever.
            if (hit != '0 && hit != event_hold) begin
                event_hold <= hit;
                cnt        <= '0;
            end else if (!cnt[HOLD_BITS-1]) begin
                cnt <= cnt + 1'b1;
            end else begin
                event_hold <= '0;
            end

            // The hit registered this cycle is the last pixel of the old frame.
            if (frame_d1) begin
                frame_hits <= acc | hit;
                acc        <= '0;
            end else begin
                acc <= acc | hit;
            end
        end
    end
`else
    assign hit        = '0;
    assign event_hold = '0;
    assign frame_hits = '0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// -----------------------------------------------------------------------------
// tb_sprite_compositor
// Directed scoreboard bench. The driver pushes the expected pixel/hit (and,
// where relevant, event_hold/frame_hits) for each raster vector; a monitor
// pops and compares when the delayed vector-valid reaches the output stage.
// The ROM is modelled as a one-cycle register of a per-channel colour.
// -----------------------------------------------------------------------------
module tb_sprite_compositor;
    import sprite_pkg::*;

    localparam int N    = 4;
    localparam int AW   = 12;
    localparam int HOLD = 4;   // hold of 2^(HOLD-1) = 8 cycles

`ifdef SPRITE_COLLISION_EN
    localparam logic [N-1:0] CMASK = 4'hf;
`else
    localparam logic [N-1:0] CMASK = 4'h0;
`endif

    logic                 clk_25Hz = 1'b0;
    logic                 rst;
    logic [COORD_W-1:0]   h_cnt, v_cnt;
    logic [N-1:0]         spr_en;
    logic [N*COORD_W-1:0] spr_x, spr_y, spr_w, spr_h;
    logic [N*AW-1:0]      rom_addr;
    logic [N*COLOR_W-1:0] rom_data, rom_color;
    logic [COLOR_W-1:0]   pixel;
    logic [N-1:0]         hit, event_hold, frame_hits;

    sprite_compositor #(.N_SPR(N), .ADDR_W(AW), .HOLD_BITS(HOLD)) dut (
        .clk_25Hz   (clk_25Hz),
        .rst        (rst),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .spr_en     (spr_en),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .spr_w      (spr_w),
        .spr_h      (spr_h),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pixel      (pixel),
        .hit        (hit),
        .event_hold (event_hold),
        .frame_hits (frame_hits)
    );

    always #20 clk_25Hz = ~clk_25Hz;

    // ROM model: data follows the requested colour one cycle later.
    always @(posedge clk_25Hz) rom_data <= rom_color;

    typedef struct {
        string          nm;
        logic [11:0]    pix;
        logic [N-1:0]   hv;
        bit             cev;
        logic [N-1:0]   ev;
        bit             cfh;
        logic [N-1:0]   fh;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;

    always @(posedge clk_25Hz) begin
        v1 <= v0;
        v2 <= v1;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compares the output stage whenever a driven vector arrives.
    always @(negedge clk_25Hz) begin
        if (v2) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: output arrived with no expectation queued");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.nm, "_pixel"}, 64'(pixel), 64'(e.pix));
                check({e.nm, "_hit"},   64'(hit),   64'(e.hv));
                if (e.cev) check({e.nm, "_event"}, 64'(event_hold), 64'(e.ev));
                if (e.cfh) check({e.nm, "_frame"}, 64'(frame_hits), 64'(e.fh));
            end
        end
    end

    localparam logic [47:0] COL = 48'habc_00f_123_0f0;  // ch3..ch0
    localparam logic [N-1:0] EN = 4'b1101;

    task automatic idle(input int n);
        h_cnt = 10'd500; v_cnt = 10'd400; spr_en = EN; rom_color = COL; v0 = 1'b0;
        repeat (n) @(negedge clk_25Hz);
    endtask

    // Drives one vector, queues its expectation, optionally checks rom_addr,
    // then advances to the next falling edge.
    task automatic vec(input string nm, input int h, input int v,
                       input logic [47:0] col, input logic [N-1:0] en,
                       input logic [11:0] pix, input logic [N-1:0] hv,
                       input bit cev, input logic [N-1:0] ev,
                       input bit cfh, input logic [N-1:0] fh,
                       input bit ca, input logic [47:0] ea);
        exp_t e;
        h_cnt = 10'(h); v_cnt = 10'(v); rom_color = col; spr_en = en; v0 = 1'b1;
        e.nm = nm; e.pix = pix; e.hv = hv & CMASK;
        e.cev = cev; e.ev = ev & CMASK; e.cfh = cfh; e.fh = fh & CMASK;
        sb.push_back(e);
        #1;
        if (ca) check({nm, "_addr"}, 64'(rom_addr), 64'(ea));
        @(negedge clk_25Hz);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        spr_x = {10'd150, 10'd115, 10'd100, 10'd100};
        spr_y = {10'd90,  10'd55,  10'd50,  10'd50};
        spr_w = {10'd0,   10'd20,  10'd100, 10'd40};
        spr_h = {10'd30,  10'd20,  10'd100, 10'd30};
        rst = 1'b1;
        idle(3);
        check("reset_pixel", 64'(pixel),      64'h fff);
        check("reset_hit",   64'(hit),        64'h0);
        check("reset_event", 64'(event_hold), 64'h0);
        check("reset_frame", 64'(frame_hits), 64'h0);
        rst = 1'b0;
        idle(2);

        // Window, address, priority and key handling.
        vec("single",   110, 60,  COL, EN, 12'h0f0, 4'b0000, 0, 0, 0, 0, 1, {12'd0, 12'd0,   12'd0, 12'd410});
        vec("overlap",  120, 60,  COL, EN, 12'h0f0, 4'b0101, 0, 0, 0, 0, 1, {12'd0, 12'd105, 12'd0, 12'd420});
        vec("ch2_key",  120, 60,  48'habc_fff_123_0f0, EN, 12'h0f0, 4'b0000, 0, 0, 0, 0, 0, 48'd0);
        vec("both_key", 120, 60,  48'habc_fff_123_fff, EN, 12'hfff, 4'b0000, 0, 0, 0, 0, 0, 48'd0);
        vec("ch0_off",  120, 60,  COL, 4'b1100, 12'h00f, 4'b0000, 0, 0, 0, 0, 1, {12'd0, 12'd105, 12'd0, 12'd0});
        vec("dis_zero", 180, 100, COL, EN, 12'hfff, 4'b0000, 0, 0, 0, 0, 1, 48'd0);
        vec("key_pass", 130, 70,  48'habc_00f_123_fff, EN, 12'h00f, 4'b0000, 0, 0, 0, 0, 1, {12'd0, 12'd315, 12'd0, 12'd830});
        vec("corner",   139, 79,  COL, EN, 12'h0f0, 4'b0000, 0, 0, 0, 0, 1, {12'd0, 12'd0,   12'd0, 12'd1199});
        vec("edge_out", 140, 79,  COL, EN, 12'hfff, 4'b0000, 0, 0, 0, 0, 1, 48'd0);
        idle(20);

        // Event hold: collision at k=0, repeated identical collision at k=3.
        for (int k = 0; k <= 12; k++) begin
            logic [N-1:0] ev_exp;
            ev_exp = (k >= 1 && k <= 9) ? 4'b0101 : 4'b0000;
            if (k == 0 || k == 3)
                vec($sformatf("hold%0d", k), 120, 60, COL, EN, 12'h0f0, 4'b0101, 1, ev_exp, 0, 0, 0, 48'd0);
            else
                vec($sformatf("hold%0d", k), 500, 400, COL, EN, 12'hfff, 4'b0000, 1, ev_exp, 0, 0, 0, 48'd0);
        end
        idle(20);

        // Reset asserted while an event is being held.
        h_cnt = 10'd120; v_cnt = 10'd60;
        @(negedge clk_25Hz);
        idle(2);
        check("midhold_event", 64'(event_hold), 64'(4'b0101 & CMASK));
        rst = 1'b1;
        @(negedge clk_25Hz);
        check("rst_event", 64'(event_hold), 64'h0);
        check("rst_hit",   64'(hit),        64'h0);
        check("rst_pixel", 64'(pixel),      64'hfff);
        rst = 1'b0;
        idle(4);

        // Frame summary: collision in frame k, reported in k+1, cleared in k+2.
        vec("frm_k",    0,   0,   COL, EN, 12'hfff, 4'b0000, 0, 0, 1, 4'b0000, 0, 48'd0);
        vec("frm_hit",  120, 60,  COL, EN, 12'h0f0, 4'b0101, 0, 0, 1, 4'b0000, 0, 48'd0);
        vec("frm_mid",  500, 400, COL, EN, 12'hfff, 4'b0000, 0, 0, 1, 4'b0000, 0, 48'd0);
        vec("frm_k1",   0,   0,   COL, EN, 12'hfff, 4'b0000, 0, 0, 1, 4'b0101, 0, 48'd0);
        vec("frm_k1b",  500, 400, COL, EN, 12'hfff, 4'b0000, 0, 0, 1, 4'b0101, 0, 48'd0);
        vec("frm_k2",   0,   0,   COL, EN, 12'hfff, 4'b0000, 0, 0, 1, 4'b0000, 0, 48'd0);
        idle(5);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: %0d expectations never matched by output", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
